// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and the
// prescaler counter-width helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROR    = 2'b00,
        MODE_ROL    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    localparam int PWM_W = 8;

    // DIV=1 still needs a 1-bit counter so the port/compare logic stays legal.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled and flags the last count
// as a tick; clr restarts the count from zero.
module led_prescaler
    import led_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate / bounce / blink a WIDTH-bit pattern once per
// DIV enabled cycles. Define LED_PATTERN_PWM_EN to add a duty-cycle dimmer.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef LED_PATTERN_PWM_EN
    input  logic [PWM_W-1:0] duty,
`endif
    output logic [WIDTH-1:0] led,
    output logic             step
);

    logic             w_tick;
    logic [WIDTH-1:0] r_pat;
    logic             r_dir;
    logic             r_step;

    led_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (w_tick)
    );

    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_rol;
    assign w_ror = {r_pat[0], r_pat[WIDTH-1:1]};
    assign w_rol = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};

    // dir: 1 = moving left (towards MSB). A load overrides a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= WIDTH'(1);
            r_dir  <= 1'b1;
            r_step <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (load) begin
                r_pat <= load_val;
            end else if (w_tick) begin
                r_step <= 1'b1;
                case (mode)
                    MODE_ROR: r_pat <= w_ror;
                    MODE_ROL: r_pat <= w_rol;
                    MODE_BOUNCE: begin
                        if (r_dir && r_pat[WIDTH-1]) begin
                            r_dir <= 1'b0;
                            r_pat <= w_ror;
                        end else if (!r_dir && r_pat[0]) begin
                            r_dir <= 1'b1;
                            r_pat <= w_rol;
                        end else begin
                            r_pat <= r_dir ? w_rol : w_ror;
                        end
                    end
                    MODE_BLINK: r_pat <= ~r_pat;
                    default:    r_pat <= r_pat;
                endcase
            end
        end
    end

    assign step = r_step;

`ifdef LED_PATTERN_PWM_EN
    logic [PWM_W-1:0] r_pwm;
    logic             w_pwm_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    assign w_pwm_on = (r_pwm < duty);
    assign led      = r_pat & {WIDTH{w_pwm_on}};
`else
    assign led = r_pat;
`endif

endmodule
